// File: rtl/stable_matching_checker.sv
// stable_matching_checker
// Sequential verifier placed after the stable-matching matcher. On start it
// captures the packed preference vector and the match list. It then checks
// that the match list is a permutation, that every s lists its partner, and
// that no blocking pair exists. The first blocking pair found is reported.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       request a check (accepted only while idle)
//   g           packed preferences: rPref in the low bits, sPref in the high bits
//   match       match list (logS bits per r) with the finish flag in the MSB
//   busy        high while a check is in progress
//   done        one-cycle pulse when the result outputs are valid
//   match_valid matching is a permutation consistent with the sPref lists
//   stable      match_valid and no blocking pair
//   blk_s       s of the first blocking pair (0 if none)
//   blk_r       r of the first blocking pair (0 if none)
module stable_matching_checker #(
  parameter int Kr = 10,
  parameter int Ks = 10,
  parameter int S  = 10,
  parameter int R  = S
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [R*Kr*$clog2(S)+S*Ks*$clog2(R)-1:0]       g,
  input  logic [R*$clog2(S):0]                           match,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           match_valid,
  output logic                                           stable,
  output logic [$clog2(S)-1:0]                           blk_s,
  output logic [$clog2(R)-1:0]                           blk_r
);

  localparam int LOGS = $clog2(S);
  localparam int LOGR = $clog2(R);
  localparam int KW   = (Ks > 1) ? $clog2(Ks) : 1;
  localparam int RW   = R * Kr * LOGS;
  localparam int GW   = RW + S * Ks * LOGR;
  localparam int MW   = R * LOGS;

  localparam logic [LOGS-1:0] R_LAST = LOGS'(R - 1);
  localparam logic [LOGS-1:0] S_LAST = LOGS'(S - 1);
  localparam logic [KW-1:0]   K_LAST = KW'(Ks - 1);
  localparam logic [LOGS:0]   S_LIM  = (LOGS+1)'(S);
  localparam logic [LOGR:0]   R_LIM  = (LOGR+1)'(R);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  state_t state, state_next;

  logic [GW-1:0]   g_r;
  logic [MW-1:0]   match_r;
  logic            finish_unused_r;
  logic [LOGS-1:0] r_cnt;
  logic [LOGS-1:0] s_cnt;
  logic [KW-1:0]   k_cnt;
  logic [S-1:0]    s_has;
  logic [LOGR-1:0] partner [S];

  // Result is built up here and only published on the DONE cycle.
  logic            res_valid;
  logic            res_stable;
  logic [LOGS-1:0] res_bs;
  logic [LOGR-1:0] res_br;

  logic [LOGS-1:0] r_pref    [R][Kr];
  logic [LOGR-1:0] s_pref    [S][Ks];
  logic [LOGS-1:0] match_arr [R];

  logic [LOGS-1:0] m;
  logic [LOGR-1:0] e;
  logic [LOGS-1:0] cur;
  logic            m_oob;
  logic            e_oob;
  logic            rank_found;
  logic            rank_is_s;
  logic            load_bad;
  logic            chk_adv_s;
  logic            chk_stable;
  logic            chk_block;
  logic            chk_k_inc;

  // Unpack the captured preference vector and match list into arrays.
  always_comb begin
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < Kr; j++) begin
        r_pref[i][j] = g_r[LOGS*(Kr*i+j) +: LOGS];
      end
    end
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < Ks; j++) begin
        s_pref[i][j] = g_r[RW + LOGR*(Ks*i+j) +: LOGR];
      end
    end
    for (int i = 0; i < R; i++) begin
      match_arr[i] = match_r[LOGS*i +: LOGS];
    end
  end

  // Per-cycle operands and the parallel rank compare at r' = e.
  // The lowest index holding either s or e's current partner decides
  // which of the two r' prefers.
  always_comb begin
    m          = match_arr[r_cnt];
    m_oob      = ({1'b0, m} >= S_LIM);
    e          = s_pref[s_cnt][k_cnt];
    e_oob      = ({1'b0, e} >= R_LIM);
    cur        = match_arr[e];
    rank_found = 1'b0;
    rank_is_s  = 1'b0;
    for (int j = 0; j < Kr; j++) begin
      if (!rank_found && ((r_pref[e][j] == s_cnt) || (r_pref[e][j] == cur))) begin
        rank_found = 1'b1;
        rank_is_s  = (r_pref[e][j] == s_cnt);
      end else begin
        rank_found = rank_found;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle decision strobes.
  always_comb begin
    state_next = state;
    load_bad   = 1'b0;
    chk_adv_s  = 1'b0;
    chk_stable = 1'b0;
    chk_block  = 1'b0;
    chk_k_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        if (m_oob || s_has[m]) begin
          load_bad   = 1'b1;
          state_next = DONE;
        end else if (r_cnt == R_LAST) begin
          state_next = CHECK;
        end else begin
          state_next = LOAD;
        end
      end
      CHECK: begin
        if (e == partner[s_cnt]) begin
          if (s_cnt == S_LAST) begin
            chk_stable = 1'b1;
            state_next = DONE;
          end else begin
            chk_adv_s  = 1'b1;
          end
        end else if (!e_oob && rank_found && rank_is_s && (s_cnt != cur)) begin
          // A blocking pair found on the last entry still wins over
          // the "partner missing" verdict.
          chk_block  = 1'b1;
          state_next = DONE;
        end else if (k_cnt == K_LAST) begin
          state_next = DONE;
        end else begin
          chk_k_inc  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: input capture, counters, bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_r             <= '0;
      match_r         <= '0;
      finish_unused_r <= 1'b0;
      r_cnt           <= '0;
      s_cnt           <= '0;
      k_cnt           <= '0;
      s_has           <= '0;
      for (int i = 0; i < S; i++) begin
        partner[i] <= '0;
      end
      res_valid       <= 1'b0;
      res_stable      <= 1'b0;
      res_bs          <= '0;
      res_br          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      match_valid     <= 1'b0;
      stable          <= 1'b0;
      blk_s           <= '0;
      blk_r           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            g_r             <= g;
            match_r         <= match[MW-1:0];
            finish_unused_r <= match[MW];
            r_cnt           <= '0;
            s_cnt           <= '0;
            k_cnt           <= '0;
            s_has           <= '0;
            res_valid       <= 1'b0;
            res_stable      <= 1'b0;
            res_bs          <= '0;
            res_br          <= '0;
            busy            <= 1'b1;
            match_valid     <= 1'b0;
            stable          <= 1'b0;
            blk_s           <= '0;
            blk_r           <= '0;
          end
        end
        LOAD: begin
          if (!load_bad) begin
            s_has[m]   <= 1'b1;
            partner[m] <= LOGR'(r_cnt);
            if (r_cnt != R_LAST) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          if (chk_stable) begin
            res_valid  <= 1'b1;
            res_stable <= 1'b1;
          end else if (chk_block) begin
            res_valid  <= 1'b1;
            res_stable <= 1'b0;
            res_bs     <= s_cnt;
            res_br     <= e;
          end else if (chk_adv_s) begin
            s_cnt <= s_cnt + 1'b1;
            k_cnt <= '0;
          end else if (chk_k_inc) begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
        DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          match_valid <= res_valid;
          stable      <= res_stable;
          blk_s       <= res_bs;
          blk_r       <= res_br;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stable_matching_checker.sv
// Self-checking bench for stable_matching_checker with S=R=Ks=Kr=4.
// A driver issues directed and random checks, pushing the reference
// model's expected result (including the done cycle) into a scoreboard;
// a monitor pops and compares whenever done pulses.
module tb_stable_matching_checker;

  localparam int NS = 4;
  localparam int NR = 4;
  localparam int KS = 4;
  localparam int KR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] g;
  logic [8:0]  match;
  logic        busy, done, match_valid, stable;
  logic [1:0]  blk_s, blk_r;

  stable_matching_checker #(.Kr(KR), .Ks(KS), .S(NS), .R(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .g(g), .match(match),
    .busy(busy), .done(done), .match_valid(match_valid), .stable(stable),
    .blk_s(blk_s), .blk_r(blk_r)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic       stab;
    logic [1:0] bs;
    logic [1:0] br;
    int         lat;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   dones  = 0;
  int   issued = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Position of x in r's preference list, KR if absent.
  function automatic int rank_of(input logic [63:0] gv, input int r, input int x);
    for (int j = 0; j < KR; j++) begin
      if (int'(gv[2*(KR*r+j) +: 2]) == x) return j;
    end
    return KR;
  endfunction

  // Reference: permutation check, then each s walks its list until its
  // partner; any r it prefers to its partner that also prefers s blocks.
  function automatic exp_t model(input logic [63:0] gv, input logic [8:0] mv);
    exp_t x;
    int   partner [NS];
    bit   has [NS];
    int   loads, checks, mr, e, cur;
    bit   found;
    x = '0;
    loads = 0;
    checks = 0;
    for (int i = 0; i < NS; i++) begin
      has[i] = 1'b0;
      partner[i] = 0;
    end
    for (int r = 0; r < NR; r++) begin
      mr = int'(mv[2*r +: 2]);
      loads++;
      if (mr >= NS || has[mr]) begin
        x.lat = loads + 1;
        return x;
      end
      has[mr] = 1'b1;
      partner[mr] = r;
    end
    for (int s = 0; s < NS; s++) begin
      found = 1'b0;
      for (int k = 0; k < KS; k++) begin
        e = int'(gv[32 + 2*(KS*s+k) +: 2]);
        checks++;
        if (e == partner[s]) begin
          found = 1'b1;
          break;
        end
        if (e < NR) begin
          cur = int'(mv[2*e +: 2]);
          if (s != cur && rank_of(gv, e, s) < rank_of(gv, e, cur)) begin
            x.valid = 1'b1;
            x.bs = 2'(s);
            x.br = 2'(e);
            x.lat = loads + checks + 1;
            return x;
          end
        end
      end
      if (!found) begin
        x.lat = loads + checks + 1;
        return x;
      end
    end
    x.valid = 1'b1;
    x.stab = 1'b1;
    x.lat = loads + checks + 1;
    return x;
  endfunction

  // Rotated lists: r and s both rank their own index first.
  function automatic logic [63:0] mk_g(input bit omit2);
    logic [63:0] gv;
    gv = '0;
    for (int r = 0; r < NR; r++)
      for (int j = 0; j < KR; j++) gv[2*(KR*r+j) +: 2] = 2'((r + j) % NS);
    for (int s = 0; s < NS; s++)
      for (int j = 0; j < KS; j++) gv[32 + 2*(KS*s+j) +: 2] = 2'((s + j) % NR);
    if (omit2) begin
      gv[32 + 2*(KS*2+0) +: 2] = 2'd0;
      gv[32 + 2*(KS*2+1) +: 2] = 2'd1;
      gv[32 + 2*(KS*2+2) +: 2] = 2'd3;
      gv[32 + 2*(KS*2+3) +: 2] = 2'd0;
    end
    return gv;
  endfunction

  function automatic logic [8:0] mk_m(input int a, input int b, input int c, input int d);
    return {1'b1, 2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  // Monitor: on every done pulse pop the oldest expectation and compare.
  always @(posedge clk) begin
    exp_t ex;
    cyc = cyc + 1;
    #1;
    if (done === 1'b1) begin
      dones++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected no pending check", cyc);
      end else begin
        ex = sb.pop_front();
        check("done_cycle", cyc, ex.cyc);
        check("match_valid", match_valid, ex.valid);
        check("stable", stable, ex.stab);
        check("blk_s", blk_s, ex.bs);
        check("blk_r", blk_r, ex.br);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  // Called at a negedge: raise start for one edge and queue the expectation.
  task automatic issue(input logic [63:0] gv, input logic [8:0] mv);
    exp_t ex;
    ex = model(gv, mv);
    ex.cyc = cyc + 1 + ex.lat;
    g = gv;
    match = mv;
    start = 1'b1;
    sb.push_back(ex);
    issued++;
    @(negedge clk);
    start = 1'b0;
    g = {$urandom, $urandom};
    match = 9'($urandom);
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", n, 0);
      issued -= sb.size();
      sb.delete();
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic run(input logic [63:0] gv, input logic [8:0] mv, input bit extra);
    issue(gv, mv);
    if (extra) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    drain();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_match_valid"}, match_valid, 1'b0);
    check({tag, "_stable"}, stable, 1'b0);
    check({tag, "_blk_s"}, blk_s, 2'd0);
    check({tag, "_blk_r"}, blk_r, 2'd0);
  endtask

  initial begin
    int p [4];
    int j, t;
    logic [8:0] mv;
    rst = 1'b1;
    start = 1'b0;
    g = '0;
    match = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Stable identity: done 9 edges after acceptance.
    run(mk_g(1'b0), mk_m(0, 1, 2, 3), 1'b0);
    // r0<->s1 and r1<->s0 swapped: blocking pair (0,0).
    run(mk_g(1'b0), mk_m(1, 0, 2, 3), 1'b0);
    // r0 and r2 both matched to s3: rejected during LOAD.
    run(mk_g(1'b0), mk_m(3, 0, 3, 1), 1'b0);
    // s2's list lacks its partner.
    run(mk_g(1'b1), mk_m(0, 1, 2, 3), 1'b0);
    // Start pulsed while busy must be ignored.
    run(mk_g(1'b0), mk_m(1, 0, 2, 3), 1'b1);

    // Reset during CHECK aborts; a start right after reset is accepted.
    issue(mk_g(1'b0), mk_m(0, 1, 2, 3));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    issued -= sb.size();
    sb.delete();
    @(negedge clk);
    check_zero("abort");
    rst = 1'b0;
    issue(mk_g(1'b0), mk_m(1, 0, 2, 3));
    drain();

    // Random preferences with permutation and arbitrary match lists.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        for (int k = 0; k < 4; k++) p[k] = k;
        for (int k = 3; k > 0; k--) begin
          j = $urandom_range(0, k);
          t = p[k];
          p[k] = p[j];
          p[j] = t;
        end
        mv = mk_m(p[0], p[1], p[2], p[3]);
        mv[8] = 1'($urandom);
      end else begin
        mv = 9'($urandom);
      end
      run({$urandom, $urandom}, mv, (i % 5 == 0));
    end

    check("done_count", dones, issued);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
